nibble_serial_adder_ctrl: RTL
=============================

// Module: nibble_serial_adder_ctrl
// PURPOSE
//   Sequencer that performs one WIDTH-bit addition a+b+cin using a single shared
//   ripple_carry_4x4 slice, one nibble per cycle, LSB nibble first.
//   The inter-nibble carry is held in a register between cycles.
//   Sits in the vedic-multiplier partial-product path as an area-lean wide adder.
//   It trades latency for one 4-bit slice instead of WIDTH/4 slices.
// PARAMETERS
//   WIDTH  16  operand/sum width in bits; multiple of 4, >= 4 (NIB = WIDTH/4 derived)
// PORTS
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous, active-low reset
//   in_valid   in   1      operands a/b/cin valid
//   in_ready   out  1      controller can accept operands
//   a          in   WIDTH  addend A
//   b          in   WIDTH  addend B
//   cin        in   1      carry-in to nibble 0
//   out_valid  out  1      sum/cout valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  registered result (a+b+cin) mod 2^WIDTH
//   cout       out  1      carry-out of the top nibble
//   busy       out  1      high while nibbles are being summed
// BEHAVIOUR
//   FSM: IDLE -> BUSY -> DONE -> IDLE. Exactly one ripple_carry_4x4 instance is used.
//   Reset (async, reset_n=0):
//     - state=IDLE; nib_idx=0; carry_reg=0; sum=0; cout=0; out_valid=0.
//     - Operand registers are cleared to 0.
//     - in_ready=(state==IDLE), so it reads 1 while in reset; busy=0.
//   IDLE:
//     - in_ready=1.
//     - On in_valid&&in_ready: latch a, b into operand regs and carry_reg<=cin.
//     - Clear nib_idx; go to BUSY.
//   BUSY (NIB cycles):
//     - Slice inputs are a_reg[4*i+:4], b_reg[4*i+:4] and carry_reg, with i=nib_idx.
//     - Each edge: sum[4*i+:4]<=s_out; carry_reg<=c_out; nib_idx<=i+1.
//     - At i==NIB-1: cout<=c_out; out_valid<=1; go to DONE.
//     - in_ready=0; in_valid is ignored.
//   DONE:
//     - out_valid=1; sum and cout are held stable until out_ready=1.
//     - On out_valid&&out_ready: out_valid<=0; go to IDLE.
//     - in_ready=0 in DONE; there is no accept on the same edge as the result handshake.
//   Latency: out_valid rises NIB edges after the accept edge.
//   Throughput: at most 1 op per NIB+2 cycles.
//   sum nibbles above nib_idx are stale during BUSY; consumers must sample only when
//   out_valid=1.
//   nib_idx is ceil(log2(NIB)) bits wide, min 1 bit.
//   No wrap hazard: nib_idx is cleared on every accept.
//   WIDTH=4: BUSY lasts 1 cycle.
//   Reset mid-operation: the op is abandoned, no result is produced, and all outputs
//   return to reset values.
//   The next accepted op after reset is computed correctly.
//   in_valid held high across DONE: the op is accepted in the IDLE cycle after the
//   result handshake. Operands are never dropped or duplicated.
// TESTING (WIDTH=16 unless stated; compare against golden a+b+cin)
//   1. Basic add:
//      - a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0.
//      - out_valid exactly 4 edges after the accept.
//   2. Full carry ripple:
//      - a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1.
//      - a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
//   3. Backpressure:
//      - Hold out_ready=0 for 5 cycles in DONE while toggling in_valid/a/b.
//      - Required: sum/cout stable, in_ready=0, no new accept.
//      - Result retires on the first out_ready=1.
//   4. Reset mid-op:
//      - Assert reset_n=0 at the 2nd BUSY cycle.
//      - Required: out_valid=0, sum=0, cout=0, busy=0, in_ready=1.
//      - Next op 0x8000+0x8000 -> sum=0x0000, cout=1.
//   5. Parameter sweep:
//      - WIDTH=4: 0xF+0x1 cin=1 -> sum=0x1, cout=1, latency 1.
//      - WIDTH=32: random 1000 ops, back-to-back in_valid, random out_ready.
//      - Required: zero mismatches.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ripple_carry_4x4
// Description : 4-bit ripple-carry adder slice (s = a + b + cin).
//               The slice is shared across nibbles by nibble_serial_adder_ctrl.
// Ports       : i_a, i_b   4-bit addends
//               i_cin      carry in
//               o_sum      4-bit sum
//               o_cout     carry out of bit 3
// Revision    : 1.0  initial release
// ============================================================================
module ripple_carry_4x4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [4:0] w_carry;

    assign w_carry[0] = i_cin;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_bit
            assign o_sum[g]     = i_a[g] ^ i_b[g] ^ w_carry[g];
            assign w_carry[g+1] = (i_a[g] & i_b[g]) | (w_carry[g] & (i_a[g] ^ i_b[g]));
        end
    endgenerate

    assign o_cout = w_carry[4];
endmodule

// ============================================================================
// Module      : nibble_serial_adder_ctrl
// Description : Computes one WIDTH-bit a+b+cin over WIDTH/4 cycles using a
//               single 4-bit ripple-carry slice, LSB nibble first. The carry
//               between nibbles is held in a register.
// Ports       : clk, reset_n        clock, asynchronous active-low reset
//               in_valid/in_ready   operand handshake (a, b, cin)
//               out_valid/out_ready result handshake (sum, cout)
//               busy                high while nibbles are being summed
// Revision    : 1.0  initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [IDX_W-1:0] c_LAST_NIB = IDX_W'(NIB - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_nib_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_out_valid;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_s_nib;
    logic             w_c_out;

    // Operand nibble mux: constant selects per candidate index keep every
    // select in range for any legal WIDTH.
    always_comb begin
        w_a_nib = 4'd0;
        w_b_nib = 4'd0;
        for (int n = 0; n < NIB; n++) begin
            if (r_nib_idx == IDX_W'(n)) begin
                w_a_nib = r_a[4*n +: 4];
                w_b_nib = r_b[4*n +: 4];
            end
        end
    end

    ripple_carry_4x4 u_slice (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_sum  (w_s_nib),
        .o_cout (w_c_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_IDLE;
            r_nib_idx   <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_carry   <= cin;
                        r_nib_idx <= '0;
                        r_state   <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    for (int n = 0; n < NIB; n++) begin
                        if (r_nib_idx == IDX_W'(n)) begin
                            r_sum[4*n +: 4] <= w_s_nib;
                        end
                    end
                    r_carry   <= w_c_out;
                    r_nib_idx <= r_nib_idx + 1'b1;
                    if (r_nib_idx == c_LAST_NIB) begin
                        r_cout      <= w_c_out;
                        r_out_valid <= 1'b1;
                        r_state     <= c_DONE;
                    end
                end
                c_DONE: begin
                    // Result is held until retired; no new accept on this edge.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign busy      = (r_state == c_BUSY);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
endmodule
`default_nettype wire
